// File: rtl/sdft_frame_scheduler_if.sv
// Handshake between the frame scheduler (master) and the SDFT core (slave):
// sample/launch toward the core, per-bin magnitude results back.
interface sdft_frame_scheduler_if #(
    parameter int DATA_WIDTH = 8,
    parameter int FREQ_BINS  = 16,
    parameter int MAG_WIDTH  = 16
);
    localparam int BIN_W = $clog2(FREQ_BINS);

    logic [DATA_WIDTH-1:0] core_sample;
    logic                  core_start;
    logic                  core_valid;
    logic [BIN_W-1:0]      core_idx;
    logic [MAG_WIDTH-1:0]  core_mag;

    modport master (
        output core_sample,
        output core_start,
        input  core_valid,
        input  core_idx,
        input  core_mag
    );

    modport slave (
        input  core_sample,
        input  core_start,
        output core_valid,
        output core_idx,
        output core_mag
    );
endinterface

// File: rtl/sdft_frame_scheduler.sv
// Sample-rate sequencer for the SDFT core: ADC conversion, core launch and a
// double-buffered magnitude bank that only swaps on a VGA frame boundary.
module sdft_frame_scheduler #(
    parameter int  DIVIDER    = 1000,
    parameter int  ADC_SETTLE = 2,
    parameter int  DATA_WIDTH = 8,
    parameter int  FREQ_BINS  = 16,
    parameter int  MAG_WIDTH  = 16,
    localparam int BIN_W      = $clog2(FREQ_BINS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_WIDTH-1:0]  adc,
    output logic                   adc_clk,
    input  logic                   vsync,
    sdft_frame_scheduler_if.master core,
    input  logic [BIN_W-1:0]       rd_idx,
    output logic [MAG_WIDTH-1:0]   rd_mag,
    output logic                   frame_swap,
    output logic                   overrun
);
    localparam int CNT_W  = $clog2(DIVIDER);
    localparam int SET_W  = (ADC_SETTLE > 1) ? $clog2(ADC_SETTLE) : 1;
    localparam int ADDR_W = BIN_W + 1;
    localparam int NWORDS = 2 * FREQ_BINS;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONVERT,
        ST_CAPTURE,
        ST_START,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t                state_reg, state_next;
    logic [SET_W-1:0]      settle_reg, settle_next;
    logic [CNT_W-1:0]      cnt_reg;
    logic [DATA_WIDTH-1:0] sample_reg;
    logic                  adc_clk_reg;
    logic                  start_reg;
    logic                  back_ready_reg;
    logic                  front_sel_reg;
    logic                  vsync_d_reg;
    logic                  frame_swap_reg;
    logic                  overrun_reg;
    logic [NWORDS-1:0]     written_reg;
    logic                  rd_hit_reg;
    logic [MAG_WIDTH-1:0]  rd_q_reg;
    logic [MAG_WIDTH-1:0]  bank_mem [NWORDS];

    logic              tick;
    logic              rise;
    logic              swap;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [NWORDS-1:0] wr_hit;

    assign tick    = (cnt_reg == CNT_W'(DIVIDER - 1));
    assign rise    = vsync & ~vsync_d_reg;
    assign swap    = rise & back_ready_reg;
    assign wr_en   = (state_reg == ST_WAIT) & core.core_valid;
    // Bank select is the MSB of the address: back bank = ~front_sel.
    assign wr_addr = {~front_sel_reg, core.core_idx};
    assign rd_addr = {front_sel_reg, rd_idx};

    for (genvar gi = 0; gi < NWORDS; gi++) begin : g_wr_hit
        assign wr_hit[gi] = wr_en && (wr_addr == ADDR_W'(gi));
    end

    always_comb begin
        state_next  = state_reg;
        settle_next = '0;
        case (state_reg)
            ST_IDLE:    if (tick) state_next = ST_CONVERT;
            ST_CONVERT: begin
                if (settle_reg == SET_W'(ADC_SETTLE - 1)) state_next = ST_CAPTURE;
                else settle_next = settle_reg + 1'b1;
            end
            ST_CAPTURE: state_next = ST_START;
            ST_START:   state_next = ST_WAIT;
            ST_WAIT: begin
                if (core.core_valid && core.core_idx == BIN_W'(FREQ_BINS - 1))
                    state_next = ST_DONE;
            end
            ST_DONE:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // adc_clk and core_start are decoded from state_next so they leave on a
    // flop and can never glitch, while keeping the state-aligned timing.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            settle_reg     <= '0;
            cnt_reg        <= '0;
            sample_reg     <= '0;
            adc_clk_reg    <= 1'b0;
            start_reg      <= 1'b0;
            back_ready_reg <= 1'b0;
            front_sel_reg  <= 1'b0;
            vsync_d_reg    <= 1'b1;
            frame_swap_reg <= 1'b0;
            overrun_reg    <= 1'b0;
            written_reg    <= '0;
            rd_hit_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            settle_reg     <= settle_next;
            cnt_reg        <= tick ? '0 : cnt_reg + 1'b1;
            adc_clk_reg    <= (state_next == ST_CONVERT);
            start_reg      <= (state_next == ST_START);
            vsync_d_reg    <= vsync;
            frame_swap_reg <= swap;
            if (swap) front_sel_reg <= ~front_sel_reg;
            if (state_reg == ST_DONE) back_ready_reg <= 1'b1;
            else if (swap || state_reg == ST_START) back_ready_reg <= 1'b0;
            if (tick && state_reg != ST_IDLE) overrun_reg <= 1'b1;
            if (state_reg == ST_CAPTURE) sample_reg <= adc;
            written_reg    <= written_reg | wr_hit;
            rd_hit_reg     <= written_reg[rd_addr];
        end
    end

    // Bank storage has no reset; the written_reg flags make never-written
    // (or written-before-reset) entries read back as zero.
    always_ff @(posedge clk) begin
        if (wr_en) bank_mem[wr_addr] <= core.core_mag;
        rd_q_reg <= bank_mem[rd_addr];
    end

    assign adc_clk          = adc_clk_reg;
    assign core.core_start  = start_reg;
    assign core.core_sample = sample_reg;
    assign frame_swap       = frame_swap_reg;
    assign overrun          = overrun_reg;
    assign rd_mag           = rd_hit_reg ? rd_q_reg : '0;
endmodule

// File: tb/tb_sdft_frame_scheduler.sv
// Randomized bench for sdft_frame_scheduler: an event-time reference model
// queues the expected outputs of every cycle; a negedge monitor checks them.
module tb_sdft_frame_scheduler;
    localparam int DIV     = 32;
    localparam int SETTLE  = 2;
    localparam int DW      = 8;
    localparam int NB      = 16;
    localparam int MW      = 16;
    localparam int BW      = $clog2(NB);
    localparam int NCYC    = 1800;
    localparam int RST_CYC = 5;

    logic          clk    = 1'b0;
    logic          reset  = 1'b1;
    logic [DW-1:0] adc    = '0;
    logic          vsync  = 1'b0;
    logic [BW-1:0] rd_idx = '0;
    logic          adc_clk;
    logic [MW-1:0] rd_mag;
    logic          frame_swap;
    logic          overrun;

    sdft_frame_scheduler_if #(.DATA_WIDTH(DW), .FREQ_BINS(NB), .MAG_WIDTH(MW)) core_bus ();

    sdft_frame_scheduler #(
        .DIVIDER(DIV), .ADC_SETTLE(SETTLE), .DATA_WIDTH(DW),
        .FREQ_BINS(NB), .MAG_WIDTH(MW)
    ) dut (
        .clk(clk), .reset(reset), .adc(adc), .adc_clk(adc_clk), .vsync(vsync),
        .core(core_bus.master), .rd_idx(rd_idx), .rd_mag(rd_mag),
        .frame_swap(frame_swap), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic          adc_clk;
        logic          start;
        logic          swap;
        logic          ovr;
        logic [DW-1:0] sample;
        logic [MW-1:0] mag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    // Reference model, kept as event timestamps rather than states.
    int            m_cnt, m_tick, m_last;
    bit            m_ready, m_front, m_ovr, m_swap, m_vs_prev;
    logic [DW-1:0] m_sample;
    logic [MW-1:0] m_rd;
    logic [MW-1:0] m_bank [2][NB];

    task automatic model_reset();
        m_cnt = 0; m_tick = -1; m_last = -1;
        m_ready = 0; m_front = 0; m_ovr = 0; m_swap = 0; m_vs_prev = 1;
        m_sample = '0; m_rd = '0;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < NB; i++) m_bank[b][i] = '0;
    endtask

    // Monitor: the DUT presents a full output set every cycle.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({adc_clk, core_bus.core_start, frame_swap, overrun, core_bus.core_sample, rd_mag}
                !== {e.adc_clk, e.start, e.swap, e.ovr, e.sample, e.mag}) begin
                $display("FAIL cycle %0d outputs: got adc_clk=%b start=%b swap=%b ovr=%b sample=%h rd_mag=%0d, expected adc_clk=%b start=%b swap=%b ovr=%b sample=%h rd_mag=%0d",
                         e.cyc, adc_clk, core_bus.core_start, frame_swap, overrun,
                         core_bus.core_sample, rd_mag, e.adc_clk, e.start, e.swap, e.ovr,
                         e.sample, e.mag);
            end else begin
                passed++;
                if (e.start) $display("cycle %0d core_start sample=%h", e.cyc, e.sample);
                if (e.swap)  $display("cycle %0d frame_swap", e.cyc);
            end
        end
    end

    initial begin
        exp_t e_drv;
        int   starts = 0, next_bin = 0, next_v = 0, gaps = 0, stall_until = 0;
        int   rst_left = 0, vs_timer = 10, start_c;
        bit   rise_at_done = 0, rst_req = 0, vs_force = 0, in_win, v, rise, swap_n;
        logic [BW-1:0] vi;
        logic [MW-1:0] vm, rd_n;

        model_reset();
        core_bus.core_valid = 1'b0;
        core_bus.core_idx   = '0;
        core_bus.core_mag   = '0;

        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk); #1;
            if (m_tick >= 0 && m_last >= 0 && c >= m_last + 2) begin
                m_tick = -1; m_last = -1;
            end
            start_c = (m_tick >= 0) ? m_tick + SETTLE + 2 : -1;
            in_win  = (m_tick >= 0) && (m_last < 0) && (c > start_c);

            if (vs_force) begin
                vsync = 1'b1; vs_force = 0; vs_timer = int'($urandom_range(3, 20));
            end else if (vs_timer == 0) begin
                vsync = ~vsync; vs_timer = int'($urandom_range(3, 40));
            end else vs_timer--;

            // Core emulator: frame 1 ramps bin*100, frame 3 stalls across
            // ticks, frame 5 puts a vsync rise on DONE, frame 7 gets reset mid-WAIT.
            v = 0; vi = BW'($urandom); vm = MW'($urandom);
            if (c == start_c) begin
                starts++; next_bin = 0; gaps = 0;
                next_v       = c + 1 + int'($urandom_range(0, 2));
                stall_until  = (starts == 3) ? c + 2 * DIV + 20 : 0;
                rise_at_done = (starts == 5);
                rst_req      = (starts == 7);
            end
            if (in_win) begin
                if (rst_req && next_bin == 8) begin
                    rst_left = 3; rst_req = 0;
                end else if (c >= stall_until && c >= next_v && next_bin < NB) begin
                    v = 1; vi = BW'(next_bin);
                    vm = (starts == 1) ? MW'(next_bin * 100) : MW'($urandom);
                    if (next_bin == NB - 1 && rise_at_done) begin
                        vsync = 1'b0; vs_force = 1; rise_at_done = 0;
                    end
                    next_bin++;
                    if (gaps < 6 && $urandom_range(0, 3) == 0) begin
                        next_v = c + 2; gaps++;
                    end else next_v = c + 1;
                end
            end else if ($urandom_range(0, 7) == 0) v = 1;

            core_bus.core_valid = v;
            core_bus.core_idx   = vi;
            core_bus.core_mag   = vm;
            reset  = (c < RST_CYC) || (rst_left > 0);
            if (rst_left > 0) rst_left--;
            adc    = DW'($urandom);
            rd_idx = m_swap ? BW'(7) : BW'($urandom);

            e_drv.cyc     = c;
            e_drv.adc_clk = (m_tick >= 0) && (c >= m_tick + 1) && (c <= m_tick + SETTLE);
            e_drv.start   = (c == start_c);
            e_drv.swap    = m_swap;
            e_drv.ovr     = m_ovr;
            e_drv.sample  = m_sample;
            e_drv.mag     = m_rd;
            exp_q.push_back(e_drv);

            if (reset) model_reset();
            else begin
                rd_n = m_bank[m_front][rd_idx];
                if (m_tick >= 0 && c == m_tick + SETTLE + 1) m_sample = adc;
                if (in_win && v) begin
                    m_bank[m_front ^ 1'b1][vi] = vm;
                    if (vi == NB - 1) m_last = c;
                end
                rise = vsync && !m_vs_prev;
                m_vs_prev = vsync;
                swap_n = rise && m_ready;
                if (swap_n) begin
                    m_ready = 0; m_front = ~m_front;
                end
                if (c == start_c) m_ready = 0;
                if (m_last >= 0 && c == m_last + 1) m_ready = 1;
                if (m_cnt == DIV - 1) begin
                    if (m_tick >= 0) m_ovr = 1;
                    else m_tick = c;
                end
                m_cnt  = (m_cnt + 1) % DIV;
                m_swap = swap_n;
                m_rd   = rd_n;
            end
        end

        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/sdft_frame_scheduler.md
# sdft_frame_scheduler

Sequencer for the time-multiplexed SDFT core: generates the ADC conversion clock at a programmable sample rate, captures each sample, launches one core update per sample and collects the per-bin magnitudes into a double-buffered bank. The bank is swapped only on a VGA frame boundary, so the bar-graph renderer always reads one complete, coherent spectrum. It sits between the ADC pins, the SDFT core and the VGA pixel logic, all in the `clk` domain.

## Interface
- `DIVIDER`, 1000: `clk` cycles per sample tick (≥ `ADC_SETTLE`+`FREQ_BINS`+4).
- `ADC_SETTLE`, 2: cycles `adc_clk` is held high per conversion (≥1).
- `DATA_WIDTH`, 8: ADC sample width.
- `FREQ_BINS`, 16: number of bins (power of two); `BIN_W` = log2(`FREQ_BINS`).
- `MAG_WIDTH`, 16: magnitude width.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `adc`  in  `DATA_WIDTH`  ADC data bus.
- `adc_clk`  out  1  ADC conversion clock.
- `vsync`  in  1  VGA vertical sync; rising edge = frame boundary.
- `core_sample`  out  `DATA_WIDTH`  captured sample, held stable until the next capture.
- `core_start`  out  1  one-cycle pulse launching a core update.
- `core_valid`  in  1  core result strobe.
- `core_idx`  in  `BIN_W`  bin index of the result.
- `core_mag`  in  `MAG_WIDTH`  bin magnitude.
- `rd_idx`  in  `BIN_W`  display read address.
- `rd_mag`  out  `MAG_WIDTH`  front-bank magnitude, registered.
- `frame_swap`  out  1  one-cycle pulse when banks swap.
- `overrun`  out  1  sticky: a tick arrived while not IDLE.

## Operation
- Tick counter runs 0..`DIVIDER`-1 and wraps; tick asserts when the count = `DIVIDER`-1. It is free-running and independent of FSM state.
- FSM states and transitions:
  - IDLE: on tick → CONVERT.
  - CONVERT: `adc_clk`=1; after `ADC_SETTLE` cycles → CAPTURE.
  - CAPTURE: `adc_clk`=0; `core_sample` ← `adc`; → START.
  - START: `core_start`=1; clear `back_ready`; → WAIT.
  - WAIT: each `core_valid` writes `core_mag` to back[`core_idx`]. When `core_valid` && `core_idx`=`FREQ_BINS`-1 → DONE. No timeout.
  - DONE: set `back_ready`; → IDLE.
- `core_valid` outside WAIT is ignored; no bank write occurs.
- Tick in any state other than IDLE: tick is dropped and `overrun` ← 1. Only `reset` clears `overrun`.
- Vsync edge detection: `vsync_d` is registered (reset value 1). rise = `vsync` & ~`vsync_d`.
- On rise with registered `back_ready`=1:
  - toggle `front_sel`;
  - clear `back_ready`;
  - pulse `frame_swap`.
- On rise with `back_ready`=0: no swap; the front bank is unchanged.
- Rise in the same cycle as DONE: no swap. The swap occurs on the next rise.
- A swap during CONVERT/CAPTURE is legal. Once `back_ready` is cleared by START, no swap can occur until the next DONE, so a partially written bank never reaches the front.
- The back bank is always the bank not selected by `front_sel`.
- `rd_mag` ← front[`rd_idx`] every cycle.
- No arithmetic on magnitudes; values are stored bit-exact.

## Timing
- Reset values:
  - `adc_clk`, `core_start`, `frame_swap`, `overrun` = 0;
  - `core_sample`, `rd_mag` = 0;
  - both banks all-zero; `front_sel` = 0; `back_ready` = 0;
  - state IDLE; tick counter 0.
- Reset mid-operation: all of the above are restored on the next edge. Any core results in flight are discarded.
- First tick occurs `DIVIDER` cycles after `reset` deasserts.
- Tick at cycle T (in IDLE):
  - `adc_clk` high for cycles T+1..T+`ADC_SETTLE`;
  - CAPTURE at T+`ADC_SETTLE`+1;
  - `core_sample` valid from T+`ADC_SETTLE`+2;
  - `core_start` high at T+`ADC_SETTLE`+2.
- Last `core_valid` at cycle L: DONE at L+1, IDLE at L+2, `back_ready` visible at L+2.
- `vsync` rising first sampled at cycle V: `frame_swap` and the `front_sel` toggle are visible at V+1.
- Read latency 1: `rd_idx` at cycle N gives `rd_mag` at N+1. The first read returning new-bank data is an `rd_idx` presented at V+1.

## Test plan
- Reset, `DIVIDER`=20, `ADC_SETTLE`=2, `adc`=8'hA5 → `adc_clk` high on cycles 21–22 after reset release; `core_sample`=8'hA5 and `core_start` pulse at cycle 24.
- Core returns bins 0..15 with `core_mag`=bin×100, then a `vsync` rise → one `frame_swap` pulse; `rd_idx`=7 returns 700 one cycle later; before the swap, `rd_mag`=0.
- `vsync` rise while in WAIT (bins 0..7 written) → no `frame_swap`; `rd_mag` still returns the previous frame's values for all bins.
- `vsync` rise in the same cycle as DONE → no swap; the next rise swaps.
- Core stalls (no `core_valid`) across two ticks → `overrun`=1 stays high, only one `core_start` issued; after the core finishes, the next tick starts normally.
- `reset` asserted mid-WAIT → all outputs 0, both banks read 0, `overrun`=0; the next tick arrives `DIVIDER` cycles after release.
